// File: rtl/uart_xfer_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// uart_xfer_sequencer_pkg
// Shared definitions for the UART bulk-transfer sequencer:
//   - default RAM address / data widths
//   - the pad byte placed in the upper half of every RAM / UART word
//   - FSM state encoding (4-bit constants, legacy-compatible)
//   - helper that tells whether a state counts as "transfer in progress"
// ---------------------------------------------------------------------------
package uart_xfer_sequencer_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Upper byte of every payload word; only bits [7:0] carry data.
  localparam logic [7:0] PAD_BYTE = 8'h00;

  typedef logic [3:0] state_t;

  localparam state_t ST_IDLE     = 4'd0;
  localparam state_t ST_RX_WAIT  = 4'd1;
  localparam state_t ST_RX_WR    = 4'd2;
  localparam state_t ST_RX_GUARD = 4'd3;
  localparam state_t ST_TX_RD    = 4'd4;
  localparam state_t ST_TX_LAT   = 4'd5;
  localparam state_t ST_TX_LD    = 4'd6;
  localparam state_t ST_TX_FIRE  = 4'd7;
  localparam state_t ST_TX_ACK   = 4'd8;
  localparam state_t ST_TX_DRAIN = 4'd9;
  localparam state_t ST_DONE     = 4'd10;

  // busy is reported in every state except IDLE and the one-cycle DONE.
  function automatic logic is_busy_state(input state_t st);
    is_busy_state = (st != ST_IDLE) && (st != ST_DONE);
  endfunction

endpackage

// File: rtl/uart_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// uart_xfer_sequencer
// Sequences the UART for bulk image transfer.
//   LOAD: streams xfer_len received bytes into image RAM starting at address 0.
//   DUMP: reads xfer_len RAM words and transmits their low bytes.
// Ports:
//   clk_50m, rst_n            clock, asynchronous active-low reset
//   start_load, start_dump    1-cycle start pulses, accepted only in IDLE
//   abort                     level, returns to IDLE from any state (no done)
//   xfer_len                  byte count, sampled on an accepted start
//   rx_ready, rx_data         uart receive side
//   ready_clr                 clears the uart rx_ready flag
//   tx_data, tx_we, wr_en     uart transmit load / start strobes
//   tx_busy                   uart transmitter busy
//   mem_addr, mem_wdata,
//   mem_we, mem_rdata         image RAM port (read data 1 cycle after addr)
//   busy, done                processor status (done is a 1-cycle pulse)
// All outputs are registered and follow the next-state decode, so every
// strobe is high exactly for the cycle its state is occupied.
// ---------------------------------------------------------------------------
module uart_xfer_sequencer
  import uart_xfer_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              start_load,
  input  logic              start_dump,
  input  logic              abort,
  input  logic [ADDR_W-1:0] xfer_len,
  input  logic              rx_ready,
  input  logic [7:0]        rx_data,
  output logic              ready_clr,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_we,
  output logic              wr_en,
  input  logic              tx_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done
);

  state_t            state_r;
  state_t            seq_state_s;
  state_t            state_nx_s;
  logic [ADDR_W-1:0] len_r;
  logic [ADDR_W-1:0] len_nx_s;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] seq_count_s;
  logic [ADDR_W-1:0] count_nx_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] seq_addr_s;
  logic [ADDR_W-1:0] addr_nx_s;
  logic [ADDR_W-1:0] count_inc_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic              last_s;
  logic [DATA_W-1:0] rx_word_s;
  logic [DATA_W-1:0] tx_word_s;
  logic              rdata_unused_s;

  logic              ready_clr_r;
  logic [DATA_W-1:0] tx_data_r;
  logic              tx_we_r;
  logic              wr_en_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic              mem_we_r;
  logic              busy_r;
  logic              done_r;

  // count_r < len_r whenever it is incremented, so neither sum can wrap.
  assign count_inc_s = count_r + ADDR_W'(1);
  assign addr_inc_s  = addr_r + ADDR_W'(1);
  assign last_s      = (count_inc_s == len_r);

  assign rx_word_s      = DATA_W'({PAD_BYTE, rx_data});
  assign tx_word_s      = DATA_W'({PAD_BYTE, mem_rdata[7:0]});
  assign rdata_unused_s = ^mem_rdata[DATA_W-1:8];

  // Transfer sequencing: next state, sampled length, byte counter, address.
  always_comb begin
    seq_state_s = state_r;
    len_nx_s    = len_r;
    seq_count_s = count_r;
    seq_addr_s  = addr_r;
    case (state_r)
      ST_IDLE: begin
        seq_count_s = '0;
        seq_addr_s  = '0;
        // start_load has priority when both pulses coincide
        if (start_load) begin
          len_nx_s    = xfer_len;
          seq_state_s = (xfer_len == '0) ? ST_DONE : ST_RX_WAIT;
        end else if (start_dump) begin
          len_nx_s    = xfer_len;
          seq_state_s = (xfer_len == '0) ? ST_DONE : ST_TX_RD;
        end else begin
          seq_state_s = ST_IDLE;
        end
      end
      ST_RX_WAIT:  seq_state_s = rx_ready ? ST_RX_WR : ST_RX_WAIT;
      ST_RX_WR:    seq_state_s = ST_RX_GUARD;
      // rx_ready is ignored here while the uart reacts to ready_clr
      ST_RX_GUARD: begin
        seq_count_s = count_inc_s;
        seq_addr_s  = addr_inc_s;
        seq_state_s = last_s ? ST_DONE : ST_RX_WAIT;
      end
      ST_TX_RD:    seq_state_s = ST_TX_LAT;
      // Normally one cycle; holds (address stable) if a frame left over from
      // an aborted transfer is still going, so tx_we never meets tx_busy.
      ST_TX_LAT:   seq_state_s = tx_busy ? ST_TX_LAT : ST_TX_LD;
      ST_TX_LD:    seq_state_s = ST_TX_FIRE;
      ST_TX_FIRE:  seq_state_s = tx_busy ? ST_TX_FIRE : ST_TX_ACK;
      ST_TX_ACK:   seq_state_s = tx_busy ? ST_TX_DRAIN : ST_TX_ACK;
      ST_TX_DRAIN: begin
        if (tx_busy) begin
          seq_state_s = ST_TX_DRAIN;
        end else begin
          seq_count_s = count_inc_s;
          seq_addr_s  = addr_inc_s;
          seq_state_s = last_s ? ST_DONE : ST_TX_RD;
        end
      end
      ST_DONE: begin
        seq_count_s = '0;
        seq_addr_s  = '0;
        seq_state_s = ST_IDLE;
      end
      default: begin
        seq_count_s = '0;
        seq_addr_s  = '0;
        seq_state_s = ST_IDLE;
      end
    endcase
  end

  // abort overrides every state and clears the counters.
  always_comb begin
    state_nx_s = abort ? ST_IDLE : seq_state_s;
    count_nx_s = abort ? '0 : seq_count_s;
    addr_nx_s  = abort ? '0 : seq_addr_s;
  end

  // FSM state, length, counter and address registers.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      len_r   <= '0;
      count_r <= '0;
      addr_r  <= '0;
    end else begin
      state_r <= state_nx_s;
      len_r   <= len_nx_s;
      count_r <= count_nx_s;
      addr_r  <= addr_nx_s;
    end
  end

  // Registered strobes and data, decoded from the state being entered.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      ready_clr_r <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_wdata_r <= '0;
      tx_we_r     <= 1'b0;
      tx_data_r   <= '0;
      wr_en_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      ready_clr_r <= (state_nx_s == ST_RX_WR);
      mem_we_r    <= (state_nx_s == ST_RX_WR);
      mem_wdata_r <= (state_nx_s == ST_RX_WR) ? rx_word_s : '0;
      tx_we_r     <= (state_nx_s == ST_TX_LD);
      tx_data_r   <= (state_nx_s == ST_TX_LD) ? tx_word_s : tx_data_r;
      // leaving TX_FIRE only happens with tx_busy low
      wr_en_r     <= (state_r == ST_TX_FIRE) && (state_nx_s == ST_TX_ACK);
      busy_r      <= is_busy_state(state_nx_s);
      done_r      <= (state_nx_s == ST_DONE);
    end
  end

  assign ready_clr = ready_clr_r;
  assign tx_data   = tx_data_r;
  assign tx_we     = tx_we_r;
  assign wr_en     = wr_en_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_uart_xfer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_uart_xfer_sequencer
// Self-checking bench: behavioural RAM, uart receiver and uart transmitter
// models around the sequencer. Expected RAM images and transmitted byte
// streams come from the transfer rules (byte i -> word i, low byte out).
// ---------------------------------------------------------------------------
module tb_uart_xfer_sequencer;

  logic        clk_50m = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_load = 1'b0;
  logic        start_dump = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] xfer_len = 16'd0;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data;
  logic        ready_clr;
  logic [15:0] tx_data;
  logic        tx_we;
  logic        wr_en;
  logic        tx_busy = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata = 16'd0;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  uart_xfer_sequencer dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .start_load(start_load), .start_dump(start_dump),
    .abort(abort), .xfer_len(xfer_len), .rx_ready(rx_ready), .rx_data(rx_data),
    .ready_clr(ready_clr), .tx_data(tx_data), .tx_we(tx_we), .wr_en(wr_en),
    .tx_busy(tx_busy), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .done(done)
  );

  always #10 clk_50m = ~clk_50m;

  // ---------------- RAM model (1-cycle read latency) ----------------
  logic [15:0] ram [0:255];
  logic        ram_clr = 1'b0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = 8'd0;
  logic [15:0] poke_data = 16'd0;

  always @(posedge clk_50m) begin
    if (ram_clr) begin
      for (int i = 0; i < 256; i++) ram[i] <= 16'd0;
    end else if (poke_en) begin
      ram[poke_addr] <= poke_data;
    end else if (mem_we) begin
      ram[mem_addr[7:0]] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr[7:0]];
  end

  // ---------------- uart receiver model ----------------
  logic [7:0] rx_bytes [0:31];
  int         rx_idx = 0;
  int         rx_n = 0;
  int         rx_wait = 0;
  logic       rx_flush = 1'b0;

  assign rx_data = rx_bytes[rx_idx[4:0]];

  always @(posedge clk_50m) begin
    if (rx_flush) begin
      rx_idx   <= 0;
      rx_ready <= 1'b0;
      rx_wait  <= 0;
    end else if (rx_ready) begin
      if (ready_clr) begin
        rx_ready <= 1'b0;
        rx_idx   <= rx_idx + 1;
        rx_wait  <= int'($urandom_range(0, 3));
      end
    end else if (rx_idx < rx_n) begin
      if (rx_wait == 0) rx_ready <= 1'b1;
      else rx_wait <= rx_wait - 1;
    end
  end

  // ---------------- uart transmitter model ----------------
  int tx_cnt = 0;
  int tx_min = 2;

  always @(posedge clk_50m) begin
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy <= 1'b0;
    end else if (wr_en) begin
      tx_busy <= 1'b1;
      tx_cnt  <= tx_min + int'($urandom_range(0, 3));
    end
  end

  // ---------------- event monitor (mid-cycle) ----------------
  logic        stats_clr = 1'b0;
  int          n_rclr = 0, n_mwe = 0, n_txwe = 0, n_wren = 0, n_done = 0, n_viol = 0, n_frames = 0;
  logic        busy_q = 1'b0;
  logic [15:0] tx_log [0:31];
  int          txwe_frames [0:31];

  always @(negedge clk_50m) begin
    if (stats_clr) begin
      n_rclr = 0; n_mwe = 0; n_txwe = 0; n_wren = 0; n_done = 0; n_viol = 0; n_frames = 0;
    end else begin
      if (busy_q && !tx_busy) n_frames++;
      if (ready_clr) n_rclr++;
      if (mem_we) n_mwe++;
      if (tx_we) begin
        tx_log[n_txwe[4:0]]      = tx_data;
        txwe_frames[n_txwe[4:0]] = n_frames;
        n_txwe++;
      end
      if (wr_en) n_wren++;
      if (done) n_done++;
      if ((wr_en || tx_we) && tx_busy) n_viol++;
    end
    busy_q = tx_busy;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50m);
      #1;
    end
  endtask

  task automatic clear_stats();
    stats_clr = 1'b1;
    tick(1);
    stats_clr = 1'b0;
  endtask

  task automatic clear_ram();
    ram_clr = 1'b1;
    tick(1);
    ram_clr = 1'b0;
  endtask

  task automatic poke(input int a, input logic [15:0] d);
    poke_en   = 1'b1;
    poke_addr = a[7:0];
    poke_data = d;
    tick(1);
    poke_en   = 1'b0;
  endtask

  // rx_bytes must be filled by the caller first
  task automatic rx_setup(input int len);
    rx_n     = 0;
    rx_flush = 1'b1;
    tick(1);
    rx_flush = 1'b0;
    rx_n     = len;
  endtask

  task automatic pulse_start(input logic sl, input logic sd, input int len);
    start_load = sl;
    start_dump = sd;
    xfer_len   = len[15:0];
    tick(1);
    start_load = 1'b0;
    start_dump = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 4000) begin
      tick(1);
      cyc++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_strobes"}, {28'd0, mem_we, ready_clr, tx_we, wr_en}, 32'd0);
  endtask

  // LOAD of rx_bytes[0..len-1]; expected RAM word i = {8'h00, byte i}
  task automatic run_load(input string tag, input int len, input logic both);
    clear_ram();
    rx_setup(len);
    clear_stats();
    pulse_start(1'b1, both, len);
    wait_done({tag, "_done"});
    tick(2);
    chk({tag, "_rclr"}, n_rclr, len);
    chk({tag, "_mwe"}, n_mwe, len);
    chk({tag, "_ndone"}, n_done, 32'd1);
    chk({tag, "_txwe"}, n_txwe + n_wren, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    for (int i = 0; i < len; i++) chk({tag, "_ram"}, {16'd0, ram[i]}, {24'd0, rx_bytes[i]});
    chk({tag, "_ram_end"}, {16'd0, ram[len]}, 32'd0);
  endtask

  // DUMP of exp_w[0..len-1]; expected tx word i = {8'h00, low byte of word i}
  logic [15:0] exp_w [0:31];

  task automatic run_dump(input string tag, input int len, input logic inject);
    for (int i = 0; i < len; i++) poke(i, exp_w[i]);
    rx_n = 0;
    clear_stats();
    pulse_start(1'b0, 1'b1, len);
    if (inject) begin
      tick(3);
      pulse_start(1'b1, 1'b0, 5);
    end
    wait_done({tag, "_done"});
    tick(2);
    chk({tag, "_txwe"}, n_txwe, len);
    chk({tag, "_wren"}, n_wren, len);
    chk({tag, "_viol"}, n_viol, 32'd0);
    chk({tag, "_mwe"}, n_mwe + n_rclr, 32'd0);
    chk({tag, "_ndone"}, n_done, 32'd1);
    for (int i = 0; i < len; i++) begin
      chk({tag, "_txd"}, {16'd0, tx_log[i]}, {24'd0, exp_w[i][7:0]});
      chk({tag, "_order"}, txwe_frames[i], i);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    int cyc;

    // reset state
    tick(3);
    chk_idle_outputs("rst_low");
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    chk_idle_outputs("rst_rel");
    chk("rst_data", {mem_wdata, tx_data}, 32'd0);

    // 1: LOAD A5,3C,FF
    rx_bytes[0] = 8'hA5; rx_bytes[1] = 8'h3C; rx_bytes[2] = 8'hFF;
    run_load("t1", 3, 1'b0);

    // 2: DUMP 1234,0056 with a stray start_load injected mid-transfer
    tx_min = 2;
    exp_w[0] = 16'h1234; exp_w[1] = 16'h0056;
    run_dump("t2", 2, 1'b1);

    // 3: both starts together -> LOAD only
    rx_bytes[0] = 8'h5A;
    run_load("t3", 1, 1'b1);

    // 4: zero-length DUMP
    clear_stats();
    pulse_start(1'b0, 1'b1, 0);
    chk("t4_done_hi", {31'd0, done}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    tick(1);
    chk("t4_done_lo", {31'd0, done}, 32'd0);
    tick(2);
    chk("t4_strobes", n_mwe + n_rclr + n_txwe + n_wren, 32'd0);
    chk("t4_ndone", n_done, 32'd1);

    // 5: abort during drain of byte 2 of 4
    tx_min = 4;
    for (int i = 0; i < 4; i++) poke(i, 16'hC0 + 16'(i));
    clear_stats();
    pulse_start(1'b0, 1'b1, 4);
    cyc = 0;
    while (!(n_wren == 2 && tx_busy) && cyc < 2000) begin
      tick(1);
      cyc++;
    end
    chk("t5_reach", {31'd0, tx_busy}, 32'd1);
    tick(1);
    abort = 1'b1;
    tick(1);
    chk_idle_outputs("t5_abort");
    abort = 1'b0;
    tick(12);
    chk("t5_ndone", n_done, 32'd0);
    chk("t5_frames", n_wren * 256 + n_txwe, 32'd2 * 256 + 32'd2);
    chk("t5_txidle", {31'd0, tx_busy}, 32'd0);
    rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22;
    run_load("t5_load", 2, 1'b0);

    // 6: reset in the middle of a LOAD
    tx_min = 2;
    rx_bytes[0] = 8'h81; rx_bytes[1] = 8'h82; rx_bytes[2] = 8'h83;
    clear_ram();
    rx_setup(3);
    clear_stats();
    pulse_start(1'b1, 1'b0, 3);
    cyc = 0;
    while (n_mwe < 1 && cyc < 500) begin
      tick(1);
      cyc++;
    end
    chk("t6_first", n_mwe, 32'd1);
    tick(1);
    #3 rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_rst");
    chk("t6_addr", {16'd0, mem_addr}, 32'd0);
    rx_n = 0;
    rx_flush = 1'b1;
    tick(2);
    rx_flush = 1'b0;
    rst_n = 1'b1;
    tick(1);
    rx_bytes[0] = 8'h4D; rx_bytes[1] = 8'hE2;
    run_load("t6_load", 2, 1'b0);

    // randomized LOAD / DUMP rounds
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) rx_bytes[i] = 8'($urandom);
      run_load("rnd_load", len, 1'b0);
      tx_min = int'($urandom_range(1, 4));
      for (int i = 0; i < len; i++) exp_w[i] = 16'($urandom);
      run_dump("rnd_dump", len, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
